md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- Initiator side of the E-stage HI/LO multiply/divide interface.
- Takes the E-stage md-class instruction and forwards it to the HI/LO unit as op, D1 and D2. Flushed or invalid ops are gated off.
- Tracks the in-flight mult/div with its own latency counter and generates the D-stage stall.
- Checks the responder's busy signal against the expected latency, and keeps performance counters.

Parameters:
- MUL_LAT, 5, cycles the responder stays busy after the issue cycle for mult/multu.
- DIV_LAT, 10, cycles the responder stays busy after the issue cycle for div/divu.
- TMO, 64, extra cycles allowed past the expected completion before a timeout error.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- E_Valid  in  1  E-stage holds a real instruction (not a bubble).
- E_Flush  in  1  E-stage instruction is being cancelled this cycle.
- E_HILOOp  in  4  decoded md op of the E-stage instruction.
- E_D1  in  32  rs operand.
- E_D2  in  32  rt operand.
- D_IsMD  in  1  D-stage instruction is any md op (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).
- HILOOp  out  4  op to the HI/LO unit.
- D1  out  32  operand to the HI/LO unit.
- D2  out  32  operand to the HI/LO unit.
- IsBusy  in  1  busy from the HI/LO unit (start OR internal busy).
- Stall  out  1  freeze F/D and bubble into E.
- InFlight  out  1  state==BUSY.
- Err  out  1  sticky protocol error.
- ErrCode  out  2  code of the first error: 1 early, 2 late/timeout, 3 illegal issue while busy.
- OpCnt  out  32  completed mult/div count.
- StallCnt  out  32  cycles with Stall=1.

Behaviour:
- Reset (async): state IDLE, Cnt=0, Tmo=0, Err=0, ErrCode=0, OpCnt=0, StallCnt=0.
  - Reset mid-operation abandons the in-flight op silently; no error is raised.
- Op gating (combinational):
  - Issue = E_Valid & ~E_Flush & (E_HILOOp != HILO_none).
  - HILOOp = Issue ? E_HILOOp : HILO_none.
  - D1/D2 pass E_D1/E_D2 through unmodified; the responder ignores them when HILOOp is none.
- Start = Issue & op in {mult, multu, div, divu}.
- FSM, IDLE:
  - On Start: load Cnt with MUL_LAT for mult/multu or DIV_LAT for div/divu, then go to BUSY.
  - Move ops (mthi/mtlo/mfhi/mflo) are passed through and the FSM stays IDLE.
  - If IsBusy=1 and Start=0: error code 2 (late), logged once.
- FSM, BUSY, each cycle:
  - Require IsBusy=1; if it is 0 while Cnt>=1, raise error code 1 (early).
  - Cnt decrements.
  - On the edge where Cnt goes 1->0: enter IDLE and increment OpCnt.
  - Any Issue while BUSY raises error code 3; the op is still forwarded and no new Cnt is loaded.
- Timeout:
  - If IsBusy is still 1 in the cycle after returning to IDLE, Tmo counts up.
  - When Tmo reaches TMO, raise error code 2.
  - Tmo clears when IsBusy=0.
- Stall = D_IsMD & (Start | state==BUSY).
  - Mult example: issue in cycle t; Stall=1 in cycles t..t+5 (6 cycles); D advances at t+6.
- StallCnt increments every cycle with Stall=1; it wraps at 2^32 with no saturation.
- OpCnt wraps likewise.
- Err and ErrCode are sticky until Rst; only the first error's code is kept.
- Simultaneous events:
  - E_Flush with a start op: no issue, no state change.
  - Completion edge together with a new Issue: cannot happen legally because of the stall; if it does, it is treated as in IDLE, i.e. the new op is accepted.

Decomposition:
- HILO_* op codes go in shared const.v: none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8.
- The default latencies also go in const.v.
- One natural sub-module, md_lat_counter: load/decrement/zero-detect plus timeout counter.

Test Plan:
- mult, E_D1=-3, E_D2=7, D_IsMD=1 throughout -> HILOOp=1 in cycle t; Stall high t..t+5; InFlight low at t+6; OpCnt=1; StallCnt=6; Err=0.
- divu 100/7 followed by mflo in D -> Stall 11 cycles; mflo reaches E with HILOOp=6 at t+11; no error.
- mult with E_Flush=1 in the same cycle -> HILOOp=0; InFlight stays 0; Stall=0; OpCnt=0.
- div issued; Rst pulsed asynchronously (between edges) at cycle t+4 -> all outputs 0 immediately; later IsBusy from the responder (also reset) is 0; Err=0.
- Responder model drops IsBusy after 3 cycles of a mult -> Err=1, ErrCode=1; later errors do not overwrite the code.
- Second mult forced into E while BUSY -> ErrCode=3; Cnt is not reloaded; OpCnt ends at 1.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
// Shared constants for the E-stage multiply/divide issue controller.
// HI/LO op encodings, default latencies, FSM and error codes.
package md_issue_ctrl_pkg;

    localparam logic [3:0] HILO_NONE  = 4'd0;
    localparam logic [3:0] HILO_MULT  = 4'd1;
    localparam logic [3:0] HILO_MULTU = 4'd2;
    localparam logic [3:0] HILO_DIV   = 4'd3;
    localparam logic [3:0] HILO_DIVU  = 4'd4;
    localparam logic [3:0] HILO_MFHI  = 4'd5;
    localparam logic [3:0] HILO_MFLO  = 4'd6;
    localparam logic [3:0] HILO_MTHI  = 4'd7;
    localparam logic [3:0] HILO_MTLO  = 4'd8;

    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF = 10;
    localparam int unsigned TMO_DEF     = 64;
    localparam int unsigned CNT_W       = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_EARLY   = 2'd1;
    localparam logic [1:0] ERR_LATE    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    function automatic logic is_start_op(input logic [3:0] op);
        return (op == HILO_MULT) || (op == HILO_MULTU) ||
               (op == HILO_DIV)  || (op == HILO_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == HILO_MULT) || (op == HILO_MULTU);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_lat_counter.sv
// Latency down-counter with last-cycle detect, plus the saturating
// post-completion timeout counter.
module md_lat_counter
    import md_issue_ctrl_pkg::*;
#(
    parameter int unsigned TMO = TMO_DEF,
    parameter int unsigned CW  = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    input  logic          tmo_en,
    input  logic          tmo_clr,
    output logic          cnt_last,
    output logic          tmo_hit
);

    localparam int unsigned TMO_W = $clog2(TMO + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end

        tmo_d = tmo_q;
        if (tmo_clr) begin
            tmo_d = '0;
        end else if (tmo_en && (tmo_q != TMO_W'(TMO))) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign cnt_last = (cnt_q == CW'(1));
    assign tmo_hit  = (tmo_q == TMO_W'(TMO));

endmodule

// File: rtl/md_issue_ctrl.sv
// Initiator side of the E-stage HI/LO interface: gates and forwards md ops,
// tracks mult/div latency, drives the D-stage stall and checks the responder.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned TMO     = TMO_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        E_Valid,
    input  logic        E_Flush,
    input  logic [3:0]  E_HILOOp,
    input  logic [31:0] E_D1,
    input  logic [31:0] E_D2,
    input  logic        D_IsMD,
    output logic [3:0]  HILOOp,
    output logic [31:0] D1,
    output logic [31:0] D2,
    input  logic        IsBusy,
    output logic        Stall,
    output logic        InFlight,
    output logic        Err,
    output logic [1:0]  ErrCode,
    output logic [31:0] OpCnt,
    output logic [31:0] StallCnt
);

    logic [0:0]  state_q, state_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] op_cnt_q, op_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic issue, start, busy_st, cnt_last, last, accept, tmo_hit;
    logic e_early, e_illegal, e_late;
    logic [CNT_W-1:0] load_val;

    assign issue   = E_Valid & ~E_Flush & (E_HILOOp != HILO_NONE);
    assign start   = issue & is_start_op(E_HILOOp);
    assign busy_st = (state_q == ST_BUSY);
    assign last    = busy_st & cnt_last;
    // A start on the completing cycle is accepted as if already idle.
    assign accept  = start & (~busy_st | last);
    assign load_val = is_mul_op(E_HILOOp) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);

    md_lat_counter #(
        .TMO (TMO),
        .CW  (CNT_W)
    ) u_lat (
        .clk      (Clk),
        .rst      (Rst),
        .load     (accept),
        .load_val (load_val),
        .dec      (busy_st),
        .tmo_en   (~busy_st & IsBusy & ~start),
        .tmo_clr  (~IsBusy),
        .cnt_last (cnt_last),
        .tmo_hit  (tmo_hit)
    );

    assign e_early   = busy_st & ~IsBusy;
    assign e_illegal = busy_st & issue & ~last;
    assign e_late    = (~busy_st & IsBusy & ~start) | tmo_hit;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_BUSY;
        end else if (last) begin
            state_d = ST_IDLE;
        end

        op_cnt_d    = op_cnt_q + 32'(last);
        stall_cnt_d = stall_cnt_q + 32'(Stall);

        err_d      = err_q;
        err_code_d = err_code_q;
        if (!err_q) begin
            if (e_early) begin
                err_d      = 1'b1;
                err_code_d = ERR_EARLY;
            end else if (e_illegal) begin
                err_d      = 1'b1;
                err_code_d = ERR_ILLEGAL;
            end else if (e_late) begin
                err_d      = 1'b1;
                err_code_d = ERR_LATE;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            op_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            op_cnt_q    <= op_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign HILOOp   = issue ? E_HILOOp : HILO_NONE;
    assign D1       = E_D1;
    assign D2       = E_D2;
    assign Stall    = D_IsMD & (start | busy_st);
    assign InFlight = busy_st;
    assign Err      = err_q;
    assign ErrCode  = err_code_q;
    assign OpCnt    = op_cnt_q;
    assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural HI/LO responder.
module tb_md_issue_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        E_Valid, E_Flush, D_IsMD, IsBusy;
    logic [3:0]  E_HILOOp, HILOOp;
    logic [31:0] E_D1, E_D2, D1, D2, OpCnt, StallCnt;
    logic        Stall, InFlight, Err;
    logic [1:0]  ErrCode;

    int checks = 0;
    int failures = 0;

    logic [7:0] rcnt;
    logic [7:0] resp_mul_lat = 8'd5;
    logic       busy_force = 1'b0;

    md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .TMO(64)) dut (
        .Clk(Clk), .Rst(Rst), .E_Valid(E_Valid), .E_Flush(E_Flush),
        .E_HILOOp(E_HILOOp), .E_D1(E_D1), .E_D2(E_D2), .D_IsMD(D_IsMD),
        .HILOOp(HILOOp), .D1(D1), .D2(D2), .IsBusy(IsBusy), .Stall(Stall),
        .InFlight(InFlight), .Err(Err), .ErrCode(ErrCode), .OpCnt(OpCnt),
        .StallCnt(StallCnt)
    );

    always #5 Clk = ~Clk;

    // Responder: busy during the start cycle and for its latency afterwards.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) rcnt <= 8'd0;
        else if (HILOOp == 4'd1 || HILOOp == 4'd2) rcnt <= resp_mul_lat;
        else if (HILOOp == 4'd3 || HILOOp == 4'd4) rcnt <= 8'd10;
        else if (rcnt != 8'd0) rcnt <= rcnt - 8'd1;
    end
    assign IsBusy = busy_force | (HILOOp >= 4'd1 && HILOOp <= 4'd4) | (rcnt != 8'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic e_idle();
        E_Valid = 1'b0; E_Flush = 1'b0; E_HILOOp = 4'd0; E_D1 = '0; E_D2 = '0;
    endtask

    initial begin
        Rst = 1'b1; D_IsMD = 1'b0;
        e_idle();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_inflight", 32'(InFlight), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_errcode", 32'(ErrCode), 32'd0);
        chk("rst_opcnt", OpCnt, 32'd0);
        chk("rst_stallcnt", StallCnt, 32'd0);
        chk("rst_hiloop", 32'(HILOOp), 32'd0);
        Rst = 1'b0;
        tick();

        // mult -3 * 7 with an md op waiting in D
        E_Valid = 1'b1; E_HILOOp = 4'd1; E_D1 = 32'hFFFF_FFFD; E_D2 = 32'd7; D_IsMD = 1'b1;
        #1;
        chk("mult_hiloop", 32'(HILOOp), 32'd1);
        chk("mult_d1", D1, 32'hFFFF_FFFD);
        chk("mult_d2", D2, 32'd7);
        chk("mult_stall_t", 32'(Stall), 32'd1);
        chk("mult_inflight_t", 32'(InFlight), 32'd0);
        tick();
        e_idle();
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk("mult_stall_busy", 32'(Stall), 32'd1);
            chk("mult_inflight_busy", 32'(InFlight), 32'd1);
            tick();
        end
        chk("mult_inflight_done", 32'(InFlight), 32'd0);
        chk("mult_stall_done", 32'(Stall), 32'd0);
        chk("mult_opcnt", OpCnt, 32'd1);
        chk("mult_stallcnt", StallCnt, 32'd6);
        chk("mult_err", 32'(Err), 32'd0);

        // divu 100/7 then mflo in D
        E_Valid = 1'b1; E_HILOOp = 4'd4; E_D1 = 32'd100; E_D2 = 32'd7; D_IsMD = 1'b1;
        #1;
        chk("divu_hiloop", 32'(HILOOp), 32'd4);
        chk("divu_stall_t", 32'(Stall), 32'd1);
        tick();
        e_idle();
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk("divu_stall_busy", 32'(Stall), 32'd1);
            tick();
        end
        chk("divu_stall_done", 32'(Stall), 32'd0);
        chk("divu_stallcnt", StallCnt, 32'd17);
        chk("divu_opcnt", OpCnt, 32'd2);
        E_Valid = 1'b1; E_HILOOp = 4'd6; D_IsMD = 1'b0;
        #1;
        chk("mflo_hiloop", 32'(HILOOp), 32'd6);
        chk("mflo_stall", 32'(Stall), 32'd0);
        tick();
        e_idle();
        chk("mflo_inflight", 32'(InFlight), 32'd0);
        chk("divu_err", 32'(Err), 32'd0);

        // flushed mult
        E_Valid = 1'b1; E_Flush = 1'b1; E_HILOOp = 4'd1; D_IsMD = 1'b1;
        #1;
        chk("flush_hiloop", 32'(HILOOp), 32'd0);
        chk("flush_stall", 32'(Stall), 32'd0);
        tick();
        e_idle();
        chk("flush_inflight", 32'(InFlight), 32'd0);
        chk("flush_opcnt", OpCnt, 32'd2);
        chk("flush_stallcnt", StallCnt, 32'd17);

        // div abandoned by an asynchronous reset mid-operation
        E_Valid = 1'b1; E_HILOOp = 4'd3; E_D1 = 32'd50; E_D2 = 32'd5; D_IsMD = 1'b1;
        tick();
        e_idle();
        repeat (3) tick();
        chk("div_inflight_pre", 32'(InFlight), 32'd1);
        #3 Rst = 1'b1;
        #1;
        chk("arst_inflight", 32'(InFlight), 32'd0);
        chk("arst_stall", 32'(Stall), 32'd0);
        chk("arst_opcnt", OpCnt, 32'd0);
        chk("arst_stallcnt", StallCnt, 32'd0);
        chk("arst_err", 32'(Err), 32'd0);
        chk("arst_hiloop", 32'(HILOOp), 32'd0);
        #2 Rst = 1'b0;
        tick();
        chk("arst_isbusy", 32'(IsBusy), 32'd0);
        tick();
        chk("arst_err_later", 32'(Err), 32'd0);

        // responder drops busy after 3 cycles of a mult
        resp_mul_lat = 8'd3;
        E_Valid = 1'b1; E_HILOOp = 4'd2; D_IsMD = 1'b1;
        tick();
        e_idle();
        repeat (3) tick();
        chk("early_err_pre", 32'(Err), 32'd0);
        tick();
        chk("early_err", 32'(Err), 32'd1);
        chk("early_code", 32'(ErrCode), 32'd1);
        tick();
        chk("early_inflight_done", 32'(InFlight), 32'd0);
        chk("early_opcnt", OpCnt, 32'd1);
        busy_force = 1'b1;
        repeat (2) tick();
        busy_force = 1'b0;
        chk("early_code_sticky", 32'(ErrCode), 32'd1);
        chk("early_err_sticky", 32'(Err), 32'd1);

        Rst = 1'b1;
        #2 Rst = 1'b0;
        resp_mul_lat = 8'd5;
        tick();
        chk("rst2_err", 32'(Err), 32'd0);

        // second mult forced into E while busy
        E_Valid = 1'b1; E_HILOOp = 4'd1; D_IsMD = 1'b1;
        tick();
        e_idle();
        tick();
        E_Valid = 1'b1; E_HILOOp = 4'd1;
        #1;
        chk("ill_hiloop_fwd", 32'(HILOOp), 32'd1);
        tick();
        e_idle();
        chk("ill_err", 32'(Err), 32'd1);
        chk("ill_code", 32'(ErrCode), 32'd3);
        repeat (2) tick();
        chk("ill_inflight_t5", 32'(InFlight), 32'd1);
        tick();
        chk("ill_inflight_t6", 32'(InFlight), 32'd0);
        repeat (3) tick();
        chk("ill_opcnt", OpCnt, 32'd1);
        chk("ill_code_sticky", 32'(ErrCode), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
